// File: rtl/shift_fixup_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : shift_fixup_scheduler
// Brief    : Constant-time sequencer that walks one sparse operand through the
//            initial-shift processor with an accumulator read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module shift_fixup_scheduler #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 553,
  parameter int ADDR_W     = 10,
  parameter int WEIGHT     = 75,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err,
  input  logic                  pos_valid,
  output logic                  pos_ready,
  input  logic [15:0]           pos,
  input  logic                  pos_dummy,
  output logic                  nrm_rd_en,
  output logic [ADDR_W-1:0]     nrm_rd_addr,
  input  logic [WORD_WIDTH-1:0] nrm_rd_data,
  output logic                  acc_rd_en,
  output logic [ADDR_W-1:0]     acc_rd_addr,
  input  logic [WORD_WIDTH-1:0] acc_rd_data,
  output logic                  acc_wr_en,
  output logic [ADDR_W-1:0]     acc_wr_addr,
  output logic [WORD_WIDTH-1:0] acc_wr_data,
  output logic                  proc_start,
  output logic [15:0]           proc_high_shift,
  output logic [9:0]            proc_acc_start_idx,
  output logic [4:0]            proc_acc_shift_idx,
  output logic [WORD_WIDTH-1:0] proc_word_zero,
  output logic [WORD_WIDTH-1:0] proc_word_551,
  output logic [WORD_WIDTH-1:0] proc_word_552,
  output logic [WORD_WIDTH-1:0] proc_acc_word,
  input  logic [WORD_WIDTH-1:0] proc_result,
  input  logic                  proc_done
);

  localparam int c_cnt_w = (WEIGHT > 0) ? $clog2(WEIGHT + 1) : 1;
  localparam int c_tmo_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [c_cnt_w-1:0] c_weight     = c_cnt_w'(WEIGHT);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
  localparam logic [c_tmo_w-1:0] c_tmo_last   = c_tmo_w'(TIMEOUT - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_one    = c_tmo_w'(1);
  localparam logic [ADDR_W-1:0]  c_addr_wrap0 = ADDR_W'(NUM_WORDS - 2);
  localparam logic [ADDR_W-1:0]  c_addr_wrap1 = ADDR_W'(NUM_WORDS - 1);
  localparam logic [31:0]        c_num_words  = 32'(NUM_WORDS);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_WAIT_POS  = 4'd2,
    S_RD_ACC    = 4'd3,
    S_LAT_ACC   = 4'd4,
    S_START     = 4'd5,
    S_WAIT_DONE = 4'd6,
    S_WRITE     = 4'd7,
    S_FINISH    = 4'd8
  } state_t;

  state_t             r_state;
  logic [1:0]         r_load_cnt;
  logic [c_cnt_w-1:0] r_count;
  logic [c_tmo_w-1:0] r_tmo;
  logic [15:0]        r_pos;
  logic               r_dummy;

  logic [9:0]         w_pos_idx;
  logic               w_out_of_range;
  logic               w_last;

  assign w_pos_idx      = pos[14:5];
  assign w_out_of_range = {22'd0, w_pos_idx} >= c_num_words;
  assign w_last         = (r_count + c_cnt_one) == c_weight;

  assign proc_high_shift    = r_pos;
  assign proc_acc_start_idx = r_pos[14:5];
  assign proc_acc_shift_idx = r_pos[4:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_load_cnt     <= 2'd0;
      r_count        <= '0;
      r_tmo          <= '0;
      r_pos          <= 16'd0;
      r_dummy        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 2'b00;
      pos_ready      <= 1'b0;
      nrm_rd_en      <= 1'b0;
      nrm_rd_addr    <= '0;
      acc_rd_en      <= 1'b0;
      acc_rd_addr    <= '0;
      acc_wr_en      <= 1'b0;
      acc_wr_addr    <= '0;
      acc_wr_data    <= '0;
      proc_start     <= 1'b0;
      proc_word_zero <= '0;
      proc_word_551  <= '0;
      proc_word_552  <= '0;
      proc_acc_word  <= '0;
    end else begin
      done       <= 1'b0;
      proc_start <= 1'b0;
      acc_rd_en  <= 1'b0;
      acc_wr_en  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            err         <= 2'b00;
            r_count     <= '0;
            r_load_cnt  <= 2'd0;
            busy        <= 1'b1;
            nrm_rd_en   <= 1'b1;
            nrm_rd_addr <= '0;
            r_state     <= S_LOAD;
          end
        end

        // Reads issue in load steps 0..2; each word lands one step later.
        S_LOAD: begin
          r_load_cnt <= r_load_cnt + 2'd1;
          case (r_load_cnt)
            2'd0: nrm_rd_addr <= c_addr_wrap0;
            2'd1: begin
              proc_word_zero <= nrm_rd_data;
              nrm_rd_addr    <= c_addr_wrap1;
            end
            2'd2: begin
              proc_word_551 <= nrm_rd_data;
              nrm_rd_en     <= 1'b0;
            end
            default: begin
              proc_word_552 <= nrm_rd_data;
              if (WEIGHT == 0) begin
                done    <= 1'b1;
                r_state <= S_FINISH;
              end else begin
                pos_ready <= 1'b1;
                r_state   <= S_WAIT_POS;
              end
            end
          endcase
        end

        S_WAIT_POS: begin
          if (pos_valid) begin
            r_pos   <= pos;
            r_dummy <= pos_dummy;
            if (w_out_of_range) begin
              err[1]  <= 1'b1;
              r_count <= r_count + c_cnt_one;
              if (w_last) begin
                pos_ready <= 1'b0;
                done      <= 1'b1;
                r_state   <= S_FINISH;
              end
            end else begin
              pos_ready   <= 1'b0;
              acc_rd_en   <= 1'b1;
              acc_rd_addr <= ADDR_W'(w_pos_idx);
              r_state     <= S_RD_ACC;
            end
          end
        end

        S_RD_ACC: r_state <= S_LAT_ACC;

        S_LAT_ACC: begin
          proc_acc_word <= acc_rd_data;
          proc_start    <= 1'b1;
          r_state       <= S_START;
        end

        S_START: begin
          r_tmo   <= '0;
          r_state <= S_WAIT_DONE;
        end

        // Dummies still wait for the processor so every position costs the same.
        S_WAIT_DONE: begin
          if (proc_done) begin
            acc_wr_en   <= 1'b1;
            acc_wr_addr <= ADDR_W'(r_pos[14:5]);
            acc_wr_data <= r_dummy ? proc_acc_word : proc_result;
            r_state     <= S_WRITE;
          end else if (r_tmo == c_tmo_last) begin
            err[0]  <= 1'b1;
            done    <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_tmo <= r_tmo + c_tmo_one;
          end
        end

        S_WRITE: begin
          r_count <= r_count + c_cnt_one;
          if (w_last) begin
            done    <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            pos_ready <= 1'b1;
            r_state   <= S_WAIT_POS;
          end
        end

        S_FINISH: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy      <= 1'b0;
          pos_ready <= 1'b0;
          nrm_rd_en <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_fixup_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_fixup_scheduler
// Brief    : Directed self-checking bench for shift_fixup_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_fixup_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic        pos_valid;
  logic        pos_ready;
  logic [15:0] pos;
  logic        pos_dummy;
  logic        nrm_rd_en;
  logic [9:0]  nrm_rd_addr;
  logic [31:0] nrm_rd_data;
  logic        acc_rd_en;
  logic [9:0]  acc_rd_addr;
  logic [31:0] acc_rd_data;
  logic        acc_wr_en;
  logic [9:0]  acc_wr_addr;
  logic [31:0] acc_wr_data;
  logic        proc_start;
  logic [15:0] proc_high_shift;
  logic [9:0]  proc_acc_start_idx;
  logic [4:0]  proc_acc_shift_idx;
  logic [31:0] proc_word_zero;
  logic [31:0] proc_word_551;
  logic [31:0] proc_word_552;
  logic [31:0] proc_acc_word;
  logic [31:0] proc_result;
  logic        proc_done;

  shift_fixup_scheduler #(
    .WORD_WIDTH(32), .NUM_WORDS(553), .ADDR_W(10), .WEIGHT(3), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .pos(pos), .pos_dummy(pos_dummy),
    .nrm_rd_en(nrm_rd_en), .nrm_rd_addr(nrm_rd_addr), .nrm_rd_data(nrm_rd_data),
    .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
    .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
    .proc_start(proc_start), .proc_high_shift(proc_high_shift),
    .proc_acc_start_idx(proc_acc_start_idx), .proc_acc_shift_idx(proc_acc_shift_idx),
    .proc_word_zero(proc_word_zero), .proc_word_551(proc_word_551),
    .proc_word_552(proc_word_552), .proc_acc_word(proc_acc_word),
    .proc_result(proc_result), .proc_done(proc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Normal memory: only the three constant words carry data.
  always @(posedge clk) begin
    if (nrm_rd_en) begin
      case (nrm_rd_addr)
        10'd0:   nrm_rd_data <= 32'hFFFFFFFF;
        10'd551: nrm_rd_data <= 32'h12345678;
        10'd552: nrm_rd_data <= 32'h0000001F;
        default: nrm_rd_data <= 32'hDEAD0000;
      endcase
    end
  end

  logic [31:0] acc_mem [0:552];
  always @(posedge clk) begin
    if (acc_rd_en) acc_rd_data <= acc_mem[acc_rd_addr];
    if (acc_wr_en) acc_mem[acc_wr_addr] <= acc_wr_data;
  end

  // Processor stub: done level three cycles after proc_start.
  logic stub_en;
  logic stub_d1, stub_d2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_d1 <= 1'b0; stub_d2 <= 1'b0; proc_done <= 1'b0;
    end else begin
      stub_d1 <= proc_start & stub_en; stub_d2 <= stub_d1; proc_done <= stub_d2;
    end
  end
  assign proc_result = {16'hC0DE, proc_high_shift};

  int          nrm_cyc_q[$];
  logic [9:0]  nrm_addr_q[$];
  int          hs_cyc_q[$];
  int          rd_cyc_q[$];
  logic [9:0]  rd_addr_q[$];
  int          ps_cyc_q[$];
  int          wr_cyc_q[$];
  logic [9:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cyc_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (nrm_rd_en) begin nrm_cyc_q.push_back(cyc); nrm_addr_q.push_back(nrm_rd_addr); end
      if (pos_valid && pos_ready) hs_cyc_q.push_back(cyc);
      if (acc_rd_en) begin rd_cyc_q.push_back(cyc); rd_addr_q.push_back(acc_rd_addr); end
      if (proc_start) ps_cyc_q.push_back(cyc);
      if (acc_wr_en) begin
        wr_cyc_q.push_back(cyc); wr_addr_q.push_back(acc_wr_addr); wr_data_q.push_back(acc_wr_data);
      end
      if (done) done_cyc_q.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    nrm_cyc_q.delete(); nrm_addr_q.delete(); hs_cyc_q.delete(); rd_cyc_q.delete();
    rd_addr_q.delete(); ps_cyc_q.delete(); wr_cyc_q.delete(); wr_addr_q.delete();
    wr_data_q.delete(); done_cyc_q.delete();
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1; s = cyc; tick(); start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] p, input logic d, output bit ok);
    pos = p; pos_dummy = d; pos_valid = 1'b1; ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (pos_ready) ok = 1'b1;
      tick();
    end
    pos_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pos_valid = 1'b0; pos = 16'd0; pos_dummy = 1'b0; stub_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, pos_ready, nrm_rd_en, acc_rd_en, acc_wr_en, proc_start} !== 7'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000000",
        {busy, done, pos_ready, nrm_rd_en, acc_rd_en, acc_wr_en, proc_start});
    end
    n_checks++;
    if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", err); end
    n_checks++;
    if ({nrm_rd_addr, acc_rd_addr, acc_wr_addr} !== 30'd0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 0", {nrm_rd_addr, acc_rd_addr, acc_wr_addr});
    end
    n_checks++;
    if ({acc_wr_data, proc_word_zero, proc_word_551, proc_word_552, proc_acc_word} !== 160'd0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0",
        {acc_wr_data, proc_word_zero, proc_word_551, proc_word_552, proc_acc_word});
    end
    n_checks++;
    if ({proc_high_shift, proc_acc_start_idx, proc_acc_shift_idx} !== 31'd0) begin
      n_fail++; $display("FAIL reset_idx: got %h expected 0",
        {proc_high_shift, proc_acc_start_idx, proc_acc_shift_idx});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int s; bit ok; bit all_ok;
    acc_mem[0] = 32'hA5A5A5A5; acc_mem[2] = 32'h11112222; acc_mem[9] = 32'h33334444;
    clear_logs();
    pulse_start(s);
    all_ok = 1'b1;
    feed(16'h0047, 1'b0, ok); all_ok &= ok;
    feed(16'h0123, 1'b0, ok); all_ok &= ok;
    feed(16'h0010, 1'b1, ok); all_ok &= ok;
    wait_done(ok); all_ok &= ok;
    @(negedge clk);
    n_checks++;
    if (all_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_progress: got %b expected 1", all_ok); end
    n_checks++;
    if (nrm_addr_q.size() != 3 || {nrm_addr_q[0], nrm_addr_q[1], nrm_addr_q[2]} !== {10'd0, 10'd551, 10'd552}) begin
      n_fail++; $display("FAIL b2b_nrm_addr: got n=%0d %0d %0d %0d expected 0 551 552",
        nrm_addr_q.size(), nrm_addr_q[0], nrm_addr_q[1], nrm_addr_q[2]);
    end
    n_checks++;
    if ({nrm_cyc_q[0] - s, nrm_cyc_q[1] - s, nrm_cyc_q[2] - s} !== {32'd1, 32'd2, 32'd3}) begin
      n_fail++; $display("FAIL b2b_nrm_cycle: got %0d %0d %0d expected 1 2 3",
        nrm_cyc_q[0] - s, nrm_cyc_q[1] - s, nrm_cyc_q[2] - s);
    end
    n_checks++;
    if ({proc_word_zero, proc_word_551, proc_word_552} !== {32'hFFFFFFFF, 32'h12345678, 32'h0000001F}) begin
      n_fail++; $display("FAIL b2b_const_words: got %h %h %h expected ffffffff 12345678 0000001f",
        proc_word_zero, proc_word_551, proc_word_552);
    end
    n_checks++;
    if (hs_cyc_q.size() != 3 || {hs_cyc_q[0] - s, hs_cyc_q[1] - s, hs_cyc_q[2] - s} !== {32'd5, 32'd13, 32'd21}) begin
      n_fail++; $display("FAIL b2b_handshake: got n=%0d %0d %0d %0d expected 5 13 21",
        hs_cyc_q.size(), hs_cyc_q[0] - s, hs_cyc_q[1] - s, hs_cyc_q[2] - s);
    end
    n_checks++;
    if (rd_addr_q.size() != 3 || {rd_addr_q[0], rd_addr_q[1], rd_addr_q[2]} !== {10'd2, 10'd9, 10'd0}
        || {rd_cyc_q[0] - s, rd_cyc_q[1] - s, rd_cyc_q[2] - s} !== {32'd6, 32'd14, 32'd22}) begin
      n_fail++; $display("FAIL b2b_acc_read: got n=%0d addr %0d@%0d expected addr 2@6",
        rd_addr_q.size(), rd_addr_q[0], rd_cyc_q[0] - s);
    end
    n_checks++;
    if (ps_cyc_q.size() != 3 || {ps_cyc_q[0] - s, ps_cyc_q[1] - s, ps_cyc_q[2] - s} !== {32'd8, 32'd16, 32'd24}) begin
      n_fail++; $display("FAIL b2b_proc_start: got n=%0d %0d %0d %0d expected 8 16 24",
        ps_cyc_q.size(), ps_cyc_q[0] - s, ps_cyc_q[1] - s, ps_cyc_q[2] - s);
    end
    n_checks++;
    if (wr_addr_q.size() != 3 || {wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]} !== {10'd2, 10'd9, 10'd0}
        || {wr_cyc_q[0] - s, wr_cyc_q[1] - s, wr_cyc_q[2] - s} !== {32'd12, 32'd20, 32'd28}) begin
      n_fail++; $display("FAIL b2b_acc_write: got n=%0d addr %0d %0d %0d at %0d %0d %0d expected 2 9 0 at 12 20 28",
        wr_addr_q.size(), wr_addr_q[0], wr_addr_q[1], wr_addr_q[2], wr_cyc_q[0] - s, wr_cyc_q[1] - s, wr_cyc_q[2] - s);
    end
    n_checks++;
    if ({wr_data_q[0], wr_data_q[1], wr_data_q[2]} !== {32'hC0DE0047, 32'hC0DE0123, 32'hA5A5A5A5}) begin
      n_fail++; $display("FAIL b2b_wr_data: got %h %h %h expected c0de0047 c0de0123 a5a5a5a5",
        wr_data_q[0], wr_data_q[1], wr_data_q[2]);
    end
    n_checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] - s != 29) begin
      n_fail++; $display("FAIL b2b_done: got n=%0d at %0d expected n=1 at 29", done_cyc_q.size(), done_cyc_q[0] - s);
    end
    n_checks++;
    if ({busy, err} !== 3'b000) begin n_fail++; $display("FAIL b2b_end_state: got busy/err %b expected 000", {busy, err}); end
    n_checks++;
    if ({proc_acc_word, proc_high_shift, proc_acc_start_idx, proc_acc_shift_idx} !== {32'hA5A5A5A5, 16'h0010, 10'd0, 5'd16}) begin
      n_fail++; $display("FAIL b2b_proc_regs: got %h %h %0d %0d expected a5a5a5a5 0010 0 16",
        proc_acc_word, proc_high_shift, proc_acc_start_idx, proc_acc_shift_idx);
    end
    tick();
  endtask

  task automatic test_dummy_and_start_ignore();
    int s; bit ok; bit all_ok;
    acc_mem[1] = 32'h5A5A0001;
    clear_logs();
    pulse_start(s);
    all_ok = 1'b1;
    feed(16'h0010, 1'b1, ok); all_ok &= ok;
    start = 1'b1; tick(); start = 1'b0;
    feed(16'h0047, 1'b0, ok); all_ok &= ok;
    feed(16'h0020, 1'b1, ok); all_ok &= ok;
    for (int n = 0; n < 100 && cyc < s + 29; n++) tick();
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (all_ok !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL dummy_busy_after_done: got progress %b busy %b expected 1 0", all_ok, busy);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({busy, nrm_rd_en} !== 2'b00 || nrm_addr_q.size() != 3) begin
      n_fail++; $display("FAIL start_ignored: got busy %b nrm_en %b reads %0d expected 0 0 3",
        busy, nrm_rd_en, nrm_addr_q.size());
    end
    n_checks++;
    if (wr_addr_q.size() != 3 || {wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]} !== {10'd0, 10'd2, 10'd1}
        || {wr_cyc_q[0] - s, wr_cyc_q[1] - s, wr_cyc_q[2] - s} !== {32'd12, 32'd20, 32'd28}) begin
      n_fail++; $display("FAIL dummy_write_timing: got n=%0d addr %0d %0d %0d at %0d %0d %0d expected 0 2 1 at 12 20 28",
        wr_addr_q.size(), wr_addr_q[0], wr_addr_q[1], wr_addr_q[2], wr_cyc_q[0] - s, wr_cyc_q[1] - s, wr_cyc_q[2] - s);
    end
    n_checks++;
    if ({wr_data_q[0], wr_data_q[1], wr_data_q[2]} !== {32'hA5A5A5A5, 32'hC0DE0047, 32'h5A5A0001}) begin
      n_fail++; $display("FAIL dummy_wr_data: got %h %h %h expected a5a5a5a5 c0de0047 5a5a0001",
        wr_data_q[0], wr_data_q[1], wr_data_q[2]);
    end
    n_checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] - s != 29) begin
      n_fail++; $display("FAIL dummy_done: got n=%0d at %0d expected n=1 at 29", done_cyc_q.size(), done_cyc_q[0] - s);
    end
    tick();
  endtask

  task automatic test_timeout();
    int s; bit ok, okd;
    stub_en = 1'b0;
    clear_logs();
    pulse_start(s);
    feed(16'h0047, 1'b0, ok);
    wait_done(okd);
    @(negedge clk);
    n_checks++;
    if ({ok, okd} !== 2'b11 || done_cyc_q.size() != 1 || done_cyc_q[0] - s != 24) begin
      n_fail++; $display("FAIL timeout_done: got progress %b n=%0d at %0d expected 11 n=1 at 24",
        {ok, okd}, done_cyc_q.size(), done_cyc_q[0] - s);
    end
    n_checks++;
    if (err !== 2'b01) begin n_fail++; $display("FAIL timeout_err: got %b expected 01", err); end
    n_checks++;
    if (wr_cyc_q.size() != 0) begin n_fail++; $display("FAIL timeout_no_write: got %0d writes expected 0", wr_cyc_q.size()); end
    n_checks++;
    if (busy !== 1'b0 || ps_cyc_q.size() != 1 || ps_cyc_q[0] - s != 8) begin
      n_fail++; $display("FAIL timeout_busy_start: got busy %b proc_start n=%0d at %0d expected 0 n=1 at 8",
        busy, ps_cyc_q.size(), ps_cyc_q[0] - s);
    end
    stub_en = 1'b1;
    tick();
  endtask

  task automatic test_range();
    int s; bit ok; bit all_ok;
    acc_mem[552] = 32'h00000000;
    clear_logs();
    pulse_start(s);
    @(negedge clk);
    n_checks++;
    if (err !== 2'b00) begin n_fail++; $display("FAIL range_err_cleared: got %b expected 00", err); end
    tick();
    all_ok = 1'b1;
    feed(16'h4520, 1'b0, ok); all_ok &= ok;
    feed(16'h4500, 1'b0, ok); all_ok &= ok;
    feed(16'h0047, 1'b0, ok); all_ok &= ok;
    wait_done(ok); all_ok &= ok;
    @(negedge clk);
    n_checks++;
    if (all_ok !== 1'b1 || err !== 2'b10) begin
      n_fail++; $display("FAIL range_err: got progress %b err %b expected 1 10", all_ok, err);
    end
    n_checks++;
    if (hs_cyc_q.size() != 3 || {hs_cyc_q[0] - s, hs_cyc_q[1] - s, hs_cyc_q[2] - s} !== {32'd5, 32'd6, 32'd14}) begin
      n_fail++; $display("FAIL range_handshake: got n=%0d %0d %0d %0d expected 5 6 14",
        hs_cyc_q.size(), hs_cyc_q[0] - s, hs_cyc_q[1] - s, hs_cyc_q[2] - s);
    end
    n_checks++;
    if (rd_addr_q.size() != 2 || {rd_addr_q[0], rd_addr_q[1]} !== {10'd552, 10'd2} || rd_cyc_q[0] - s != 7) begin
      n_fail++; $display("FAIL range_acc_read: got n=%0d addr %0d %0d first at %0d expected 552 2 first at 7",
        rd_addr_q.size(), rd_addr_q[0], rd_addr_q[1], rd_cyc_q[0] - s);
    end
    n_checks++;
    if (wr_addr_q.size() != 2 || {wr_addr_q[0], wr_addr_q[1]} !== {10'd552, 10'd2}
        || {wr_data_q[0], wr_data_q[1]} !== {32'hC0DE4500, 32'hC0DE0047}) begin
      n_fail++; $display("FAIL range_acc_write: got n=%0d %0d:%h %0d:%h expected 552:c0de4500 2:c0de0047",
        wr_addr_q.size(), wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
    end
    n_checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] - s != 22) begin
      n_fail++; $display("FAIL range_done: got n=%0d at %0d expected n=1 at 22", done_cyc_q.size(), done_cyc_q[0] - s);
    end
    tick();
  endtask

  task automatic test_reset_midjob();
    int s; bit ok; bit all_ok;
    clear_logs();
    pulse_start(s);
    feed(16'h0047, 1'b0, ok);
    for (int n = 0; n < 50 && cyc < s + 10; n++) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, pos_ready, acc_rd_en, acc_wr_en, proc_start, err} !== 8'b0) begin
      n_fail++; $display("FAIL midjob_reset_strobes: got %b expected 00000000",
        {busy, done, pos_ready, acc_rd_en, acc_wr_en, proc_start, err});
    end
    n_checks++;
    if ({proc_word_zero, proc_acc_word, proc_high_shift} !== 80'd0) begin
      n_fail++; $display("FAIL midjob_reset_regs: got %h expected 0", {proc_word_zero, proc_acc_word, proc_high_shift});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    n_checks++;
    if (ok !== 1'b1 || wr_cyc_q.size() != 0) begin
      n_fail++; $display("FAIL midjob_no_write: got progress %b writes %0d expected 1 0", ok, wr_cyc_q.size());
    end
    clear_logs();
    pulse_start(s);
    all_ok = 1'b1;
    feed(16'h0047, 1'b0, ok); all_ok &= ok;
    feed(16'h0123, 1'b0, ok); all_ok &= ok;
    feed(16'h0020, 1'b0, ok); all_ok &= ok;
    wait_done(ok); all_ok &= ok;
    @(negedge clk);
    n_checks++;
    if (all_ok !== 1'b1 || wr_addr_q.size() != 3 || {wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]} !== {10'd2, 10'd9, 10'd1}
        || {wr_data_q[0], wr_data_q[1], wr_data_q[2]} !== {32'hC0DE0047, 32'hC0DE0123, 32'hC0DE0020}) begin
      n_fail++; $display("FAIL clean_job_writes: got n=%0d data %h %h %h expected c0de0047 c0de0123 c0de0020",
        wr_addr_q.size(), wr_data_q[0], wr_data_q[1], wr_data_q[2]);
    end
    n_checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] - s != 29 || {busy, err} !== 3'b000 || proc_word_551 !== 32'h12345678) begin
      n_fail++; $display("FAIL clean_job_done: got n=%0d at %0d busy/err %b w551 %h expected n=1 at 29 000 12345678",
        done_cyc_q.size(), done_cyc_q[0] - s, {busy, err}, proc_word_551);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 553; i++) acc_mem[i] = 32'd0;
    test_reset();
    test_back_to_back();
    test_dummy_and_start_ignore();
    test_timeout();
    test_range();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
